// File: rtl/quad_pkg.sv
// Shared types for the quadrature step decoder:
// FSM states, 2-bit phase codes and direction helpers.
package quad_pkg;

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // {a,b}: up order is 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic is_up(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    return (prev == PH_00 && cur == PH_10) ||
           (prev == PH_10 && cur == PH_11) ||
           (prev == PH_11 && cur == PH_01) ||
           (prev == PH_01 && cur == PH_00);
  endfunction

  function automatic logic is_down(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    return (prev == PH_00 && cur == PH_01) ||
           (prev == PH_01 && cur == PH_11) ||
           (prev == PH_11 && cur == PH_10) ||
           (prev == PH_10 && cur == PH_00);
  endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One encoder channel: SYNC_STAGES synchroniser then a
// FILT_LEN-cycle deglitcher. Ports: clk, clear, raw, bypass, filt.
module quad_chan_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  input  logic bypass,
  output logic filt
);

  localparam int CW =
    (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sh;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = sh[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sh   <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sh <= {sh[SYNC_STAGES-2:0], raw};
      if (bypass) begin
        filt <= sync;
        cnt  <= '0;
      end else if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // new level held long enough
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: sync + deglitch, 4x decode to step/up_down,
// illegal-transition err pulse and saturating err_cnt. clear = async reset.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             qa,
  input  logic             qb,
  input  logic             en,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int INIT_LEN = SYNC_STAGES + FILT_LEN;
  localparam int IW       = $clog2(INIT_LEN + 1);
  localparam logic [IW-1:0] INIT_LAST =
    IW'(INIT_LEN - 1);

  state_t      state;
  logic [IW-1:0] init_cnt;
  logic        filt_a;
  logic        filt_b;
  logic [1:0]  prv;
  logic [1:0]  cur;
  logic        track;
  logic        up;
  logic        dn;
  logic        bad;

  assign track = (state == TRACK);

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt_a (
    .clk    (clk),
    .clear  (clear),
    .raw    (qa),
    .bypass (!track),
    .filt   (filt_a)
  );

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt_b (
    .clk    (clk),
    .clear  (clear),
    .raw    (qb),
    .bypass (!track),
    .filt   (filt_b)
  );

  assign cur = {filt_a, filt_b};
  assign up  = is_up(prv, cur);
  assign dn  = is_down(prv, cur);
  // both channels moving at once: direction unknown
  assign bad = ((prv ^ cur) == 2'b11);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= INIT;
      init_cnt <= '0;
      prv      <= PH_00;
      step     <= 1'b0;
      err      <= 1'b0;
      up_down  <= 1'b1;
      err_cnt  <= '0;
    end else begin
      prv  <= cur;
      step <= track && en && (up || dn);
      err  <= track && en && bad;

      // direction follows the pins even while muted
      if (track && up) begin
        up_down <= 1'b1;
      end else if (track && dn) begin
        up_down <= 1'b0;
      end

      if (err_clr) begin
        err_cnt <= '0;
      end else if (track && en && bad &&
                   err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end

      unique case (state)
        INIT: begin
          if (init_cnt == INIT_LAST) begin
            state <= TRACK;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        TRACK: begin
          state <= TRACK;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: phase table plus
// hand sequences for latency, saturation, err_clr and clear.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       clear;
  logic       qa;
  logic       qb;
  logic       en;
  logic       err_clr;
  logic       step;
  logic       up_down;
  logic       err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  quad_step_decoder dut (
    .clk     (clk),
    .clear   (clear),
    .qa      (qa),
    .qb      (qb),
    .en      (en),
    .err_clr (err_clr),
    .step    (step),
    .up_down (up_down),
    .err     (err),
    .err_cnt (err_cnt)
  );

  int total = 0;
  int bad   = 0;

  // pulse monitor and downstream position counter model
  int         n_step = 0;
  int         n_err  = 0;
  logic [7:0] pos    = 8'h00;
  bit         both   = 1'b0;

  always @(negedge clk) begin
    if (step) begin
      n_step = n_step + 1;
      pos = up_down ? pos + 8'd1 : pos - 8'd1;
    end
    if (err) n_err = n_err + 1;
    if (step && err) both = 1'b1;
  end

  typedef struct {
    logic a;
    logic b;
    logic en;
    int   hold;
    int   steps;
    int   errs;
    int   ud;
    int   ec;
  } vec_t;

  vec_t tv[22];

  task automatic check(input string name,
                       input int act,
                       input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int e0;
    int lat;
    logic [7:0] base;
    logic [7:0] d;
    logic [1:0] rev[4];

    //     a  b  en hold st er ud ec
    tv[0]  = '{1, 0, 1, 10, 1, 0, 1, 0};
    tv[1]  = '{1, 1, 1, 10, 1, 0, 1, 0};
    tv[2]  = '{0, 1, 1, 10, 1, 0, 1, 0};
    tv[3]  = '{0, 0, 1, 10, 1, 0, 1, 0};
    tv[4]  = '{0, 1, 1, 10, 1, 0, 0, 0};
    tv[5]  = '{1, 1, 1, 10, 1, 0, 0, 0};
    tv[6]  = '{1, 0, 1, 10, 1, 0, 0, 0};
    tv[7]  = '{0, 0, 1, 10, 1, 0, 0, 0};
    tv[8]  = '{1, 0, 1,  3, 0, 0, 0, 0};
    tv[9]  = '{0, 0, 1, 10, 0, 0, 0, 0};
    tv[10] = '{1, 0, 1,  4, 0, 0, 0, 0};
    tv[11] = '{0, 0, 1, 10, 2, 0, 0, 0};
    tv[12] = '{1, 1, 1, 10, 0, 1, 0, 1};
    tv[13] = '{0, 0, 1, 10, 0, 1, 0, 2};
    tv[14] = '{1, 0, 0, 10, 0, 0, 1, 2};
    tv[15] = '{1, 1, 0, 10, 0, 0, 1, 2};
    tv[16] = '{0, 1, 0, 10, 0, 0, 1, 2};
    tv[17] = '{0, 0, 0, 10, 0, 0, 1, 2};
    tv[18] = '{1, 1, 0, 10, 0, 0, 1, 2};
    tv[19] = '{0, 0, 0, 10, 0, 0, 1, 2};
    tv[20] = '{0, 0, 1, 10, 0, 0, 1, 2};
    tv[21] = '{0, 1, 1, 10, 1, 0, 0, 2};

    // pins at 11 through reset: no spurious activity
    clear   = 1'b1;
    qa      = 1'b1;
    qb      = 1'b1;
    en      = 1'b1;
    err_clr = 1'b0;
    tick(2);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    check("rst_ud", up_down, 1);
    check("rst_ecnt", err_cnt, 0);
    clear = 1'b0;
    s0 = n_step;
    e0 = n_err;
    tick(50);
    check("hold11_steps", n_step - s0, 0);
    check("hold11_errs", n_err - e0, 0);
    check("hold11_ud", up_down, 1);
    check("hold11_ecnt", err_cnt, 0);

    // restart from 00 for the phase table
    clear = 1'b1;
    qa    = 1'b0;
    qb    = 1'b0;
    tick(2);
    clear = 1'b0;
    tick(12);

    for (int i = 0; i < 22; i++) begin
      qa = tv[i].a;
      qb = tv[i].b;
      en = tv[i].en;
      s0 = n_step;
      e0 = n_err;
      tick(tv[i].hold);
      check($sformatf("row%0d_steps", i),
            n_step - s0, tv[i].steps);
      check($sformatf("row%0d_errs", i),
            n_err - e0, tv[i].errs);
      check($sformatf("row%0d_ud", i),
            up_down, tv[i].ud);
      check($sformatf("row%0d_ecnt", i),
            err_cnt, tv[i].ec);
    end

    // latency: 01 -> 11 (down), pin edge to step
    lat = 0;
    qa  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (step) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 7);
    tick(5);
    check("lat_ud", up_down, 0);

    // back to 00 via 10, then reverse cycle on a counter
    qb = 1'b0;
    tick(10);
    qa = 1'b0;
    tick(10);
    rev[0] = 2'b01;
    rev[1] = 2'b11;
    rev[2] = 2'b10;
    rev[3] = 2'b00;
    base = pos;
    s0 = n_step;
    for (int i = 0; i < 4; i++) begin
      {qa, qb} = rev[i];
      tick(10);
    end
    d = pos - base;
    check("rev_steps", n_step - s0, 4);
    check("rev_counter", d, 8'hFC);
    check("rev_ud", up_down, 0);

    // error counter: clear, saturate, clear priority
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("eclr_alone", err_cnt, 0);
    s0 = n_step;
    e0 = n_err;
    for (int i = 0; i < 300; i++) begin
      qa = (i % 2 == 0);
      qb = (i % 2 == 0);
      tick(6);
    end
    tick(10);
    check("sat_errs", n_err - e0, 300);
    check("sat_steps", n_step - s0, 0);
    check("sat_ecnt", err_cnt, 255);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("eclr_sat", err_cnt, 0);
    qa = 1'b1;
    qb = 1'b1;
    tick(10);
    check("ecnt_one", err_cnt, 1);
    qa = 1'b0;
    qb = 1'b0;
    tick(6);
    err_clr = 1'b1;
    tick(1);
    check("coinc_err", err, 1);
    check("coinc_ecnt", err_cnt, 0);
    err_clr = 1'b0;
    tick(5);
    check("coinc_after", err_cnt, 0);

    // clear mid-operation with pins left at 11
    qa = 1'b1;
    qb = 1'b1;
    tick(10);
    qb = 1'b0;
    tick(10);
    check("pre_clr_ud", up_down, 0);
    check("pre_clr_ecnt", err_cnt, 1);
    qb = 1'b1;
    tick(3);
    #2;
    clear = 1'b1;
    #1;
    check("mid_clr_step", step, 0);
    check("mid_clr_err", err, 0);
    check("mid_clr_ud", up_down, 1);
    check("mid_clr_ecnt", err_cnt, 0);
    tick(2);
    clear = 1'b0;
    s0 = n_step;
    e0 = n_err;
    tick(30);
    check("rel_steps", n_step - s0, 0);
    check("rel_errs", n_err - e0, 0);
    check("rel_ud", up_down, 1);
    qb = 1'b0;
    tick(10);
    check("post_steps", n_step - s0, 1);
    check("post_ud", up_down, 0);

    check("step_err_both", both, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
